inst_boot_loader: RTL and testbench

//   Upstream feeder of the CPU top. Accepts a byte stream (from a UART RX
//   or host bridge), assembles little-endian 32-bit words and writes them

---
 rtl/inst_boot_loader.sv | 118 +++++++++++
 tb/tb_inst_boot_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_boot_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into 32-bit
// words, writes them to instruction RAM via the CPU debug port, then releases the CPU.
module inst_boot_loader #(
  parameter int unsigned MAX_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned RST_HOLD  = 4,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        debug,
  output logic        inst_ram_write_enable,
  output logic [31:0] inst_ram_write_data,
  output logic [31:0] inst_ram_write_address,
  output logic        cpu_reset,
  output logic [31:0] words_loaded,
  output logic        done,
  output logic        error
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    RELEASE,
    RUN,
    ERR
  } state_t;

  state_t            state, state_next;
  logic [1:0]        byte_cnt;
  logic [23:0]       shift_q;
  logic [31:0]       len_q;
  logic [TO_W-1:0]   idle_cnt;
  logic [7:0]        hold_cnt;
  logic              accept;
  logic              last_byte;
  logic              timeout_hit;
  logic [31:0]       word;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    byte_ready            = (state == IDLE) || (state == LEN) || (state == DATA);
    debug                 = (state == LEN) || (state == DATA) || (state == WRITE);
    inst_ram_write_enable = (state == WRITE);
    cpu_reset             = (state != RUN);
    done                  = (state == RUN);
    error                 = (state == ERR);
    accept                = byte_valid && byte_ready;
    last_byte             = (byte_cnt == 2'd3);
    timeout_hit           = (idle_cnt == TO_W'(TIMEOUT - 1));
    word                  = {byte_data, shift_q};
    state_next            = state;
    case (state)
      IDLE: if (accept) state_next = LEN;
      LEN: begin
        if (accept && last_byte) begin
          if (word == 32'd0)           state_next = RELEASE;
          else if (word > MAX_WORDS)   state_next = ERR;
          else                         state_next = DATA;
        end else if (!accept && timeout_hit) begin
          state_next = ERR;
        end
      end
      DATA: begin
        if (accept && last_byte)           state_next = WRITE;
        else if (!accept && timeout_hit)   state_next = ERR;
      end
      WRITE:   state_next = (words_loaded + 32'd1 == len_q) ? RELEASE : DATA;
      RELEASE: if (hold_cnt == 8'(RST_HOLD)) state_next = RUN;
      RUN:     state_next = RUN;
      ERR:     state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  // One shared shift register assembles both the length header and data words;
  // byte_cnt wraps naturally because header and words are both 4 bytes long.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt               <= '0;
      shift_q                <= '0;
      len_q                  <= '0;
      idle_cnt               <= '0;
      hold_cnt               <= '0;
      inst_ram_write_data    <= '0;
      inst_ram_write_address <= BASE_ADDR;
      words_loaded           <= '0;
    end else begin
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift_q  <= word[31:8];
      end
      if (accept && last_byte && state == LEN)  len_q <= word;
      if (accept && last_byte && state == DATA) inst_ram_write_data <= word;
      if (state == WRITE) begin
        inst_ram_write_address <= inst_ram_write_address + 32'd4;
        words_loaded           <= words_loaded + 32'd1;
      end
      if (accept)
        idle_cnt <= '0;
      else if (state == LEN || state == DATA)
        idle_cnt <= idle_cnt + TO_W'(1);
      hold_cnt <= (state == RELEASE) ? hold_cnt + 8'd1 : '0;
    end
  end

endmodule

// File: tb/tb_inst_boot_loader.sv
// Directed bench for inst_boot_loader: stimulus pushes expected RAM writes into a
// scoreboard queue; a negedge monitor pops and compares each write strobe.
module tb_inst_boot_loader;

  localparam int unsigned MAX_WORDS = 1024;
  localparam logic [31:0] BASE      = 32'h0;
  localparam int unsigned RST_HOLD  = 4;
  localparam int unsigned TIMEOUT   = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        debug;
  logic        inst_ram_write_enable;
  logic [31:0] inst_ram_write_data;
  logic [31:0] inst_ram_write_address;
  logic        cpu_reset;
  logic [31:0] words_loaded;
  logic        done;
  logic        error;

  inst_boot_loader #(
    .MAX_WORDS (MAX_WORDS),
    .BASE_ADDR (BASE),
    .RST_HOLD  (RST_HOLD),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .byte_valid             (byte_valid),
    .byte_data              (byte_data),
    .byte_ready             (byte_ready),
    .debug                  (debug),
    .inst_ram_write_enable  (inst_ram_write_enable),
    .inst_ram_write_data    (inst_ram_write_data),
    .inst_ram_write_address (inst_ram_write_address),
    .cpu_reset              (cpu_reset),
    .words_loaded           (words_loaded),
    .done                   (done),
    .error                  (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int   n_pass = 0;
  int   n_total = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  logic [7:0] frame[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && inst_ram_write_enable) begin
      check("byte_ready_in_write", {31'd0, byte_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write",
                 inst_ram_write_address, inst_ram_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", inst_ram_write_address, mon_e.addr);
        check("write_data", inst_ram_write_data, mon_e.data);
      end
    end
  end

  task automatic add_byte(input logic [7:0] b);
    frame.push_back(b);
  endtask

  task automatic push_word(input logic [31:0] w);
    frame.push_back(w[7:0]);
    frame.push_back(w[15:8]);
    frame.push_back(w[23:16]);
    frame.push_back(w[31:24]);
  endtask

  // Returns #1 after the edge on which the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int n = 0; n < 20 && !got; n++) begin
      got = byte_ready;
      @(posedge clk); #1;
    end
    if (!got) begin
      n_total++;
      $display("FAIL byte_accept: byte 0x%02h not accepted within 20 cycles", b);
    end
  endtask

  // hold=1 keeps byte_valid high through the whole image, including WRITE cycles.
  task automatic send_frame(input bit hold);
    for (int i = 0; i < frame.size(); i++) begin
      send_byte(frame[i]);
      if (!hold && i != frame.size() - 1) begin
        byte_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    byte_valid = 1'b0;
    frame.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    byte_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int n = 0; n < 20 && !done; n++) begin
      @(posedge clk); #1;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_debug",   {31'd0, debug}, 32'd0);
    check("rst_we",      {31'd0, inst_ram_write_enable}, 32'd0);
    check("rst_data",    inst_ram_write_data, 32'd0);
    check("rst_addr",    inst_ram_write_address, BASE);
    check("rst_cpu_rst", {31'd0, cpu_reset}, 32'd1);
    check("rst_words",   words_loaded, 32'd0);
    check("rst_done",    {31'd0, done}, 32'd0);
    check("rst_error",   {31'd0, error}, 32'd0);
    reset = 1'b0;
    check("rst_ready",   {31'd0, byte_ready}, 32'd1);

    // Two-word image from explicit bytes.
    foreach (frame[i]) frame.delete(i);
    add_byte(8'h02); add_byte(8'h00); add_byte(8'h00); add_byte(8'h00);
    add_byte(8'h13); add_byte(8'h00); add_byte(8'h01); add_byte(8'h24);
    add_byte(8'h08); add_byte(8'h00); add_byte(8'h42); add_byte(8'h20);
    exp_q.push_back({32'h0000_0000, 32'h2401_0013});
    exp_q.push_back({32'h0000_0004, 32'h2042_0008});
    send_frame(1'b0);
    repeat (RST_HOLD + 1) begin @(posedge clk); #1; end
    check("a_done_early",  {31'd0, done}, 32'd0);
    check("a_cpurst_early", {31'd0, cpu_reset}, 32'd1);
    @(posedge clk); #1;
    check("a_done",      {31'd0, done}, 32'd1);
    check("a_cpurst",    {31'd0, cpu_reset}, 32'd0);
    check("a_words",     words_loaded, 32'd2);
    check("a_debug",     {31'd0, debug}, 32'd0);
    check("a_run_ready", {31'd0, byte_ready}, 32'd0);
    check("a_q_empty",   exp_q.size(), 32'd0);

    // Zero-length image: RELEASE straight after the header.
    do_reset();
    push_word(32'h0);
    send_frame(1'b0);
    check("b_debug",  {31'd0, debug}, 32'd0);
    check("b_cpurst", {31'd0, cpu_reset}, 32'd1);
    repeat (RST_HOLD) begin @(posedge clk); #1; end
    check("b_done_early", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    check("b_done",  {31'd0, done}, 32'd1);
    check("b_words", words_loaded, 32'd0);

    // Oversize length 0x401.
    do_reset();
    push_word(32'h0000_0401);
    send_frame(1'b0);
    check("c_error",  {31'd0, error}, 32'd1);
    check("c_cpurst", {31'd0, cpu_reset}, 32'd1);
    check("c_ready",  {31'd0, byte_ready}, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("c_error_sticky", {31'd0, error}, 32'd1);
    check("c_done",   {31'd0, done}, 32'd0);

    // Stream stalls after two data bytes.
    do_reset();
    push_word(32'h1);
    add_byte(8'h11); add_byte(8'h22);
    send_frame(1'b0);
    repeat (TIMEOUT - 1) begin @(posedge clk); #1; end
    check("d_error_early", {31'd0, error}, 32'd0);
    @(posedge clk); #1;
    check("d_error", {31'd0, error}, 32'd1);
    check("d_words", words_loaded, 32'd0);

    // Reset mid-load: word 0 written, word 1 partially assembled then discarded.
    do_reset();
    push_word(32'h2);
    push_word(32'hCAFE_0001);
    add_byte(8'hAA); add_byte(8'hBB); add_byte(8'hCC);
    exp_q.push_back({32'h0000_0000, 32'hCAFE_0001});
    send_frame(1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("e_we",     {31'd0, inst_ram_write_enable}, 32'd0);
    check("e_debug",  {31'd0, debug}, 32'd0);
    check("e_addr",   inst_ram_write_address, BASE);
    check("e_words",  words_loaded, 32'd0);
    check("e_ready",  {31'd0, byte_ready}, 32'd1);
    reset = 1'b0;
    push_word(32'h2);
    push_word(32'hDEAD_BEEF);
    push_word(32'h0BAD_F00D);
    exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
    exp_q.push_back({32'h0000_0004, 32'h0BAD_F00D});
    send_frame(1'b0);
    wait_done("e_done");
    check("e_words_final", words_loaded, 32'd2);

    // byte_valid held high across the whole image, including WRITE cycles.
    do_reset();
    push_word(32'h3);
    push_word(32'h1122_3344);
    push_word(32'h5566_7788);
    push_word(32'h99AA_BBCC);
    exp_q.push_back({32'h0000_0000, 32'h1122_3344});
    exp_q.push_back({32'h0000_0004, 32'h5566_7788});
    exp_q.push_back({32'h0000_0008, 32'h99AA_BBCC});
    send_frame(1'b1);
    wait_done("f_done");
    check("f_words",   words_loaded, 32'd3);
    check("f_addr",    inst_ram_write_address, 32'h0000_000C);
    check("f_q_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1, "watchdog");
  end

endmodule
